// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
//   Shared types and helpers for the registered 3-to-8 strobe decoder.
//   - state_t  : FSM states of decoder3to8_pulse (IDLE, PULSE, GAP)
//   - CODE_W   : width of an encoded line index
//   - LINES    : number of decoded output lines
//   - onehot8(): line index -> one-hot line vector
// ---------------------------------------------------------------------------
package decoder_pkg;

   localparam int CODE_W = 3;
   localparam int LINES  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   function automatic logic [LINES-1:0] onehot8(input logic [CODE_W-1:0] code);
      logic [LINES-1:0] v;
      v       = '0;
      v[code] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/decoder3to8.sv
// ---------------------------------------------------------------------------
// decoder3to8
//   Purely combinational 3-to-8 decoder with enable; the receive-side mirror
//   of encoder8to3. Usable standalone.
//   Ports:
//     en    in  1  line selected; 0 forces all outputs low
//     code  in  3  encoded line index 0..7
//     out   out 8  one-hot line vector (all zeros when en=0)
// ---------------------------------------------------------------------------
module decoder3to8
   import decoder_pkg::*;
(
   input  logic              en,
   input  logic [CODE_W-1:0] code,
   output logic [LINES-1:0]  out
);

   assign out = en ? onehot8(code) : '0;

endmodule

// File: rtl/decoder3to8_pulse.sv
// ---------------------------------------------------------------------------
// decoder3to8_pulse
//   Registered 3-to-8 decoder producing a PULSE_LEN-cycle one-hot strobe per
//   accepted code, followed by a one-cycle idle gap.
//   Optional feature: define DECODER_QUEUE_EN to add a one-entry skid register
//   so a code can be accepted while a strobe is in progress.
//   Ports:
//     clk        in  1  rising-edge clock
//     reset_n    in  1  asynchronous active-low reset
//     in_valid   in  1  code presented
//     in_ready   out 1  code can be accepted this cycle (registered state only)
//     in_code    in  3  encoded line index
//     in_en      in  1  code meaningful; 0 = no line selected (discarded)
//     out        out 8  one-hot strobe, zero when not pulsing
//     out_valid  out 1  registered |out
//     busy       out 1  PULSE or GAP, or skid occupied
// ---------------------------------------------------------------------------
module decoder3to8_pulse
   import decoder_pkg::*;
#(
   parameter int PULSE_LEN = 4
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_en,
   output logic [LINES-1:0]  out,
   output logic              out_valid,
   output logic              busy
);

   localparam int CNT_W = $clog2(PULSE_LEN + 1);
   // Counter preload: the edge that loads it is already the first strobe cycle.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [LINES-1:0]  out_nxt;
   logic [LINES-1:0]  dec_in;
   logic              xfer;

   decoder3to8 u_dec (
      .en   (in_en),
      .code (in_code),
      .out  (dec_in)
   );

   assign xfer = in_valid & in_ready;

`ifdef DECODER_QUEUE_EN
   logic              skid_full, skid_full_nxt;
   logic [CODE_W-1:0] skid_code, skid_code_nxt;

   assign in_ready = !skid_full;
   assign busy     = (state != IDLE) || skid_full;
`else
   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      out_nxt   = out;
`ifdef DECODER_QUEUE_EN
      skid_full_nxt = skid_full;
      skid_code_nxt = skid_code;
`endif
      unique case (state)
         IDLE: begin
            // en=0 codes are consumed here without leaving IDLE.
            if (xfer && in_en) begin
               state_nxt = PULSE;
               out_nxt   = dec_in;
               cnt_nxt   = CNT_LOAD;
            end
         end
         PULSE: begin
            if (cnt == '0) begin
               state_nxt = GAP;
               out_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
`ifdef DECODER_QUEUE_EN
            if (xfer && in_en) begin
               skid_full_nxt = 1'b1;
               skid_code_nxt = in_code;
            end
`endif
         end
         GAP: begin
            state_nxt = IDLE;
`ifdef DECODER_QUEUE_EN
            // A queued code wins; in_ready is low while the skid is full,
            // so the two branches never compete for the same edge.
            if (skid_full) begin
               state_nxt     = PULSE;
               out_nxt       = onehot8(skid_code);
               cnt_nxt       = CNT_LOAD;
               skid_full_nxt = 1'b0;
            end else if (xfer && in_en) begin
               state_nxt = PULSE;
               out_nxt   = dec_in;
               cnt_nxt   = CNT_LOAD;
            end
`endif
         end
         default: begin
            state_nxt = IDLE;
            out_nxt   = '0;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         out       <= out_nxt;
         out_valid <= |out_nxt;
      end
   end

`ifdef DECODER_QUEUE_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         skid_full <= 1'b0;
         skid_code <= '0;
      end else begin
         skid_full <= skid_full_nxt;
         skid_code <= skid_code_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_decoder3to8_pulse.sv
// ---------------------------------------------------------------------------
// tb_decoder3to8_pulse
//   Bench for decoder3to8_pulse: a PULSE_LEN=4 instance exercised by directed
//   sequences and a vector table, with a queue of expected strobes checked in
//   order by a monitor; plus a PULSE_LEN=1 instance. Honors DECODER_QUEUE_EN.
// ---------------------------------------------------------------------------
module tb_decoder3to8_pulse;

   localparam int PL = 4;
`ifdef DECODER_QUEUE_EN
   localparam int   EXP_PERIOD = PL + 1;
   localparam logic GAP_READY  = 1'b1;
`else
   localparam int   EXP_PERIOD = PL + 2;
   localparam logic GAP_READY  = 1'b0;
`endif

   logic       clk;
   logic       reset_n;
   logic       in_valid, in_en, in_ready, out_valid, busy;
   logic [2:0] in_code;
   logic [7:0] out;
   logic       v1, e1, r1, ov1, b1;
   logic [2:0] c1;
   logic [7:0] o1;

   int total = 0;
   int bad   = 0;
   logic [7:0] sb[$];

   decoder3to8_pulse #(.PULSE_LEN(PL)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .in_en(in_en), .out(out), .out_valid(out_valid), .busy(busy)
   );

   decoder3to8_pulse #(.PULSE_LEN(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_ready(r1),
      .in_code(c1), .in_en(e1), .out(o1), .out_valid(ov1), .busy(b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected strobe pushed just before the edge that takes the transfer.
   always @(negedge clk) begin
      #2;
      if (reset_n && in_valid && in_ready && in_en)
         sb.push_back(8'h01 << in_code);
   end

   // Monitor: strobe order, hold, length and out_valid consistency.
   logic [7:0] prev_out = 8'h00;
   int         plen = 0;
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_out = 8'h00;
         plen     = 0;
      end else begin
         chk("mon_onehot", 32'($countones(out) <= 1), 32'd1);
         chk("mon_out_valid", 32'(out_valid), 32'(|out));
         if (out != 8'h00 && prev_out == 8'h00) begin
            if (sb.size() == 0) chk("mon_unexpected_pulse", 32'(out), 32'd0);
            else chk("mon_order", 32'(out), 32'(sb.pop_front()));
            plen = 1;
         end else if (out != 8'h00) begin
            chk("mon_hold", 32'(out), 32'(prev_out));
            plen++;
         end else if (prev_out != 8'h00) begin
            chk("mon_pulse_len", 32'(plen), 32'(PL));
         end
         prev_out = out;
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: sim time exceeded, got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0] code;
      logic       en;
      logic [7:0] exp_out;
   } vec_t;

   vec_t vecs[6];
   int   s0, s1, nacc, nacc_q;
   int   acc_t[3];
   logic [7:0] prevo;
   logic acc;
   logic [2:0] qcodes[3];

   initial begin
      vecs[0] = '{code: 3'd5, en: 1'b1, exp_out: 8'h20};
      vecs[1] = '{code: 3'd0, en: 1'b1, exp_out: 8'h01};
      vecs[2] = '{code: 3'd7, en: 1'b1, exp_out: 8'h80};
      vecs[3] = '{code: 3'd3, en: 1'b0, exp_out: 8'h00};
      vecs[4] = '{code: 3'd2, en: 1'b1, exp_out: 8'h04};
      vecs[5] = '{code: 3'd6, en: 1'b0, exp_out: 8'h00};

      reset_n = 1'b0;
      in_valid = 1'b0; in_code = 3'd0; in_en = 1'b0;
      v1 = 1'b0; c1 = 3'd0; e1 = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_pl1_out", 32'(o1), 32'd0);
      reset_n = 1'b1;

      // Code 5, full strobe and gap timing
      @(negedge clk);
      in_valid = 1'b1; in_code = 3'd5; in_en = 1'b1;
      chk("c5_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < PL; k++) begin
         chk("c5_pulse", 32'(out), 32'h20);
         @(negedge clk);
      end
      chk("c5_gap_out", 32'(out), 32'd0);
      chk("c5_gap_busy", 32'(busy), 32'd1);
      chk("c5_gap_ready", 32'(in_ready), 32'(GAP_READY));
      @(negedge clk);
      chk("c5_idle_ready", 32'(in_ready), 32'd1);
      chk("c5_idle_busy", 32'(busy), 32'd0);

      // en=0 code discarded, next code taken on the following edge
      @(negedge clk);
      in_valid = 1'b1; in_code = 3'd0; in_en = 1'b0;
      @(negedge clk);
      chk("en0_out", 32'(out), 32'd0);
      chk("en0_busy", 32'(busy), 32'd0);
      chk("en0_ready", 32'(in_ready), 32'd1);
      in_code = 3'd2; in_en = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("en0_next_out", 32'(out), 32'h04);
      repeat (PL + 1) @(negedge clk);
      chk("en0_next_done", 32'(in_ready), 32'd1);

      // Vector table
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_code = vecs[i].code; in_en = vecs[i].en;
         chk("vec_ready", 32'(in_ready), 32'd1);
         @(negedge clk);
         in_valid = 1'b0;
         chk("vec_out", 32'(out), 32'(vecs[i].exp_out));
         chk("vec_busy", 32'(busy), 32'(vecs[i].en));
         if (vecs[i].en) repeat (PL + 1) @(negedge clk);
         chk("vec_idle_out", 32'(out), 32'd0);
         chk("vec_idle_ready", 32'(in_ready), 32'd1);
      end

      // Reset in the 2nd cycle of a code-7 strobe
      @(negedge clk);
      in_valid = 1'b1; in_code = 3'd7; in_en = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("r7_first", 32'(out), 32'h80);
      @(negedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("r7_async_out", 32'(out), 32'd0);
      chk("r7_async_out_valid", 32'(out_valid), 32'd0);
      chk("r7_async_busy", 32'(busy), 32'd0);
      chk("r7_rst_ready", 32'(in_ready), 32'd1);
      chk("r7_sb_empty", 32'(sb.size()), 32'd0);
      in_valid = 1'b1; in_code = 3'd1; in_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("r7_no_xfer_in_reset", 32'(out), 32'd0);
      in_valid = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      chk("r7_post_ready", 32'(in_ready), 32'd1);
      chk("r7_post_busy", 32'(busy), 32'd0);
      for (int k = 0; k < PL + 2; k++) begin
         chk("r7_no_residual", 32'(out), 32'd0);
         @(negedge clk);
      end

      // Codes 3,3 with in_valid held: two pulses, fixed period
      in_valid = 1'b1; in_code = 3'd3; in_en = 1'b1;
      nacc = 0; s0 = -1; s1 = -1; prevo = 8'h00;
      for (int t = 0; t < 30; t++) begin
         if (in_valid && in_ready) nacc++;
         @(negedge clk);
         if (nacc == 2) in_valid = 1'b0;
         if (out == 8'h08 && prevo == 8'h00) begin
            if (s0 < 0) s0 = t;
            else if (s1 < 0) s1 = t;
         end
         prevo = out;
      end
      in_valid = 1'b0;
      chk("b2b_accepts", 32'(nacc), 32'd2);
      chk("b2b_two_pulses", 32'(s1 >= 0), 32'd1);
      chk("b2b_period", 32'(s1 - s0), 32'(EXP_PERIOD));

`ifdef DECODER_QUEUE_EN
      // Codes 1,2,4 offered continuously through the skid
      qcodes[0] = 3'd1; qcodes[1] = 3'd2; qcodes[2] = 3'd4;
      nacc_q = 0;
      for (int j = 0; j < 3; j++) acc_t[j] = -1;
      @(negedge clk);
      in_valid = 1'b1; in_en = 1'b1; in_code = qcodes[0];
      for (int t = 0; t < 40; t++) begin
         acc = in_valid && in_ready;
         if (t == 2) chk("q_ready_low_skid_full", 32'(in_ready), 32'd0);
         if (acc) begin
            acc_t[nacc_q] = t;
            nacc_q++;
         end
         @(negedge clk);
         if (acc) begin
            if (nacc_q < 3) in_code = qcodes[nacc_q];
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("q_acc0", 32'(acc_t[0]), 32'd0);
      chk("q_acc1", 32'(acc_t[1]), 32'd1);
      chk("q_acc2", 32'(acc_t[2]), 32'(PL + 2));
      chk("q_idle", 32'(busy), 32'd0);
`endif

      // PULSE_LEN=1 instance, code 6
      @(negedge clk);
      v1 = 1'b1; c1 = 3'd6; e1 = 1'b1;
      chk("pl1_ready", 32'(r1), 32'd1);
      @(negedge clk);
      v1 = 1'b0;
      chk("pl1_out", 32'(o1), 32'h40);
      chk("pl1_out_valid", 32'(ov1), 32'd1);
      @(negedge clk);
      chk("pl1_gap_out", 32'(o1), 32'd0);
      chk("pl1_gap_busy", 32'(b1), 32'd1);
      chk("pl1_gap_ready", 32'(r1), 32'(GAP_READY));
      @(negedge clk);
      chk("pl1_idle_out", 32'(o1), 32'd0);
      chk("pl1_idle_busy", 32'(b1), 32'd0);
      chk("pl1_idle_ready", 32'(r1), 32'd1);

      repeat (2) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decoder3to8_pulse.md
# decoder3to8_pulse

Registered 3-to-8 decoder that turns an encoded line index into a timed one-hot strobe. It is the receive-side counterpart of the team's 8-to-3 and priority encoders: a 3-bit code plus an enable arrives over a valid/ready handshake, and the decoded output line is driven high for a fixed number of cycles. A guaranteed idle gap follows each strobe. The block sits between the request-arbitration logic and the per-line consumers that need a clean, bounded pulse instead of a level.

## Interface
- `PULSE_LEN`, default 4: cycles each strobe is held high; legal range 1..255.
- `CNT_W`, localparam: `$clog2(PULSE_LEN+1)`, the width of the pulse counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  sole clock, rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  code presented.
- `in_ready`  output  1  block can accept a code this cycle.
- `in_code`  input  3  encoded line index 0..7.
- `in_en`  input  1  code is meaningful; 0 means "no line selected". This resolves the encoder's ambiguous all-zero output.
- `out`  output  8  one-hot strobe; all zeros when not pulsing.
- `out_valid`  output  1  high whenever `out` is non-zero.
- `busy`  output  1  high in PULSE or GAP, or while the skid buffer is occupied.

## Operation
- A transfer happens on a rising edge when `in_valid & in_ready` is true.
- FSM states: IDLE, PULSE, GAP.
- IDLE: `in_ready`=1.
  - Accept with `in_en`=1: go to PULSE, register `out` = 1<<`in_code`, load counter = PULSE_LEN-1.
  - Accept with `in_en`=0: the code is consumed and discarded; state stays IDLE and `out` stays 0.
- PULSE: `out` is held. Each edge decrements the counter. On the edge where counter==0: go to GAP and set `out`=0.
- GAP: exactly one cycle with `out`=0. The next state is IDLE, or PULSE when a queued code exists (see Configuration).
- `out_valid` = |`out`. It is registered alongside `out` and never combinational from the inputs.
- At most one bit of `out` is ever set.
- Codes are decoded in acceptance order; none is dropped except `in_en`=0 codes.
- Reset, asserted at any time including mid-pulse:
  - `out`=0, `out_valid`=0, `busy`=0, state=IDLE, counter=0, skid buffer empty.
  - `in_ready` reads 1 during reset, but no transfer is taken while `reset_n`=0.

## Timing
- Latency: accept at edge k gives `out` high from edge k through edge k+PULSE_LEN, i.e. exactly PULSE_LEN cycles.
- GAP occupies edges k+PULSE_LEN to k+PULSE_LEN+1.
- Without the queue, `in_ready` returns at k+PULSE_LEN+1, so one code is accepted per PULSE_LEN+2 cycles.
- PULSE_LEN=1: single-cycle strobe, then the one-cycle GAP.
- `in_ready` is a function of registered state only. There is no combinational path from `in_valid` to `in_ready`.
- Two consecutive identical codes always produce two distinct pulses, separated by at least one zero cycle.

## Configuration
- `DECODER_QUEUE_EN` defined: adds a one-entry skid register (code + full flag).
  - `in_ready` = !skid_full in every state.
  - An `in_en`=1 code accepted in PULSE or GAP is stored in the skid.
  - Leaving GAP with the skid full goes straight to PULSE with the skid code, which clears the skid.
  - A code accepted during the GAP cycle with the skid empty goes straight to PULSE as well.
  - Back-to-back period becomes PULSE_LEN+1.
  - `in_en`=0 codes never occupy the skid.
- Not defined: no skid. `in_ready` = (state==IDLE), with the period given in Timing.

## Structure
- Package `decoder_pkg`: state enum (IDLE, PULSE, GAP), `CODE_W`=3, `LINES`=8, and function `onehot8(code)`.
- One sub-module, `decoder3to8`: purely combinational, with enable, so `out` = en ? 1<<code : 0. It mirrors `encoder8to3` and is reusable standalone.
- The top level holds the FSM, counter, output register and the optional skid.

## Test plan
- Reset, then accept code 5 with en=1 and PULSE_LEN=4 → `out`=8'h20 for 4 cycles, then 1 zero cycle, then `in_ready`=1.
- Accept code 0 with en=0 → `out` stays 8'h00, `busy`=0, `in_ready` stays 1, and the next code is accepted on the following edge.
- Send codes 3 then 3 back-to-back with `in_valid` held → two separate 8'h08 pulses, gap ≥1 cycle. Period is 6 cycles without `DECODER_QUEUE_EN` and 5 with it.
- Assert `reset_n`=0 in the 2nd cycle of a code-7 pulse → `out` is 8'h00 immediately (asynchronously). After release: IDLE, `in_ready`=1, no residual pulse.
- With `DECODER_QUEUE_EN`, offer codes 1, 2, 4 continuously → 1 and 2 are taken (2 into the skid), `in_ready`=0 until the skid drains, and the outputs are 8'h02, 8'h04, 8'h10 in order.
- PULSE_LEN=1 with code 6 → `out`=8'h40 for exactly 1 cycle, then 1 gap cycle.
